// File: rtl/fbcpu_memory_if.sv
// Bus bundle between the FBCPU core / program loader (master) and the
// fbcpu_memory responder (slave). Signal names follow the core's own names.
//
// Handshake: a loader word moves on a rising clock edge where ld_valid and
// ld_ready are both 1. A valid word is held stable until that edge, and
// ld_ready never depends combinationally on ld_valid.
interface fbcpu_memory_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);
  // core port
  logic [ADDRESS_WIDTH-1:0] MAR;
  logic [DATA_WIDTH-1:0]    MDRIn;
  logic                     RAMWr;
  logic [DATA_WIDTH-1:0]    MDROut;
  // program loader stream
  logic                     ld_start;
  logic                     ld_valid;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic                     ld_done;
  // status
  logic                     cpu_hold;
  logic                     wr_fault;

  modport master (
    output MAR, MDRIn, RAMWr, ld_start, ld_valid, ld_data, ld_last,
    input  MDROut, ld_ready, ld_done, cpu_hold, wr_fault
  );

  modport slave (
    input  MAR, MDRIn, RAMWr, ld_start, ld_valid, ld_data, ld_last,
    output MDROut, ld_ready, ld_done, cpu_hold, wr_fault
  );
endinterface

// File: rtl/fbcpu_memory.sv
// fbcpu_memory: single-port word RAM answering the FBCPU core, with a
// sequential program loader that owns the array while active and holds the
// core in reset through cpu_hold. The whole array is zeroed after reset.
//
// Optional feature macro: FBCPU_MEM_WRPROT_EN
//   defined   -> core writes below PROT_LIMIT are dropped and raise sticky wr_fault
//   undefined -> every address is writable, wr_fault is tied to 0
//
// State machine: CLEAR -> RUN -> LOAD -> RUN. The current state is exposed on
// dbg_state_o (0 = CLEAR, 1 = RUN, 2 = LOAD).
module fbcpu_memory #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int PROT_LIMIT    = 8
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active low
  fbcpu_memory_if.slave        bus,
  output logic [1:0]           dbg_state_o
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
  // One extra bit so a PROT_LIMIT equal to the depth still compares correctly.
  localparam logic [ADDRESS_WIDTH:0] PROT_LIM = (ADDRESS_WIDTH+1)'(PROT_LIMIT);

`ifdef FBCPU_MEM_WRPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t                    state_q;
  logic [ADDRESS_WIDTH-1:0]  ptr_q;       // shared clear / load pointer
  logic [DATA_WIDTH-1:0]     mdrout_q;
  logic                      ld_ready_q;
  logic                      ld_done_q;
  logic                      cpu_hold_q;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

  // single write port, steered by the state machine
  logic                      mem_we;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;

  logic                      prot_hit;
  logic                      core_wr_ok;
  logic                      load_xfer;
  logic                      load_exit;

  // A core write to the protected low region is only blocked when the feature is built in.
  assign prot_hit   = PROT_EN && ({1'b0, bus.MAR} < PROT_LIM);
  assign core_wr_ok = bus.RAMWr && !prot_hit;

  // A loader word moves only while LOAD is advertising ready.
  assign load_xfer  = (state_q == ST_LOAD) && bus.ld_valid && ld_ready_q;
  // Leave LOAD after the flagged last word or after filling the top word,
  // so the pointer never wraps back onto word 0.
  assign load_exit  = load_xfer && (bus.ld_last || (ptr_q == LAST_ADDR));

  // Select who writes the array this cycle: clearer, core, or loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
      end
      ST_RUN: begin
        mem_we    = core_wr_ok;
        mem_addr  = bus.MAR;
        mem_wdata = bus.MDRIn;
      end
      ST_LOAD: begin
        mem_we    = load_xfer;
        mem_addr  = ptr_q;
        mem_wdata = bus.ld_data;
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
  end

  // Array write port; contents are deliberately not reset (CLEAR zeroes them).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Control FSM with registered read data and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      mdrout_q   <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          mdrout_q   <= '0;
          ld_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
          ptr_q      <= ptr_q + 1'b1;
          if (ptr_q == LAST_ADDR) begin
            state_q    <= ST_RUN;
            cpu_hold_q <= 1'b0;
          end
        end
        ST_RUN: begin
          // Read-first: the old word is captured even when this edge writes it.
          mdrout_q   <= mem_q[bus.MAR];
          ld_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          if (bus.ld_start) begin
            state_q    <= ST_LOAD;
            ptr_q      <= '0;
            ld_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          mdrout_q <= '0;
          if (load_xfer) begin
            ptr_q <= ptr_q + 1'b1;
          end
          if (load_exit) begin
            state_q    <= ST_RUN;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          ptr_q      <= '0;
          mdrout_q   <= '0;
          ld_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef FBCPU_MEM_WRPROT_EN
  logic wr_fault_q;

  // Sticky record of any dropped core write into the protected region.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_fault_q <= 1'b0;
    end else if ((state_q == ST_RUN) && bus.RAMWr && prot_hit) begin
      wr_fault_q <= 1'b1;
    end
  end

  assign bus.wr_fault = wr_fault_q;
`else
  assign bus.wr_fault = 1'b0;
`endif

  assign bus.MDROut   = mdrout_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fbcpu_memory.sv
// Testbench for fbcpu_memory: reset/clear, table-driven core accesses,
// read-first corner, full and partial program loads, write protection and
// reset in the middle of a load. Read data is checked through an expected queue.
module tb_fbcpu_memory;

  localparam int AW    = 6;
  localparam int DW    = 10;
  localparam int DEPTH = 64;
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fbcpu_memory_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [1:0] dbg_state;

  fbcpu_memory #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PROT_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int ld_ptr;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  always @(negedge clk) begin
    if (bus.ld_done) done_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0h expected <empty queue>", name, bus.MDROut);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(bus.MDROut), 32'(e));
    end
  endtask

  function automatic bit writable(input logic [AW-1:0] a);
`ifdef FBCPU_MEM_WRPROT_EN
    return (a >= 6'd8);
`else
    return (a == a);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rd(input logic [AW-1:0] a);
    bus.MAR   = a;
    bus.RAMWr = 1'b0;
    exp_q.push_back(model[a]);
    step();
    sb_check($sformatf("rd[%0d]", a));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.MAR   = a;
    bus.MDRIn = d;
    bus.RAMWr = 1'b1;
    exp_q.push_back(model[a]);         // read-first: old word comes back
    if (writable(a)) model[a] = d;
    step();
    bus.RAMWr = 1'b0;
    sb_check($sformatf("wr_rd[%0d]", a));
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    ld_ptr = 0;
    chk("load_state", 32'(dbg_state), 32'(S_LOAD));
    chk("load_ready", 32'(bus.ld_ready), 32'd1);
    chk("load_hold",  32'(bus.cpu_hold), 32'd1);
  endtask

  task automatic ld_word(input logic [DW-1:0] d, input logic last);
    int n = 0;
    while (!bus.ld_ready && n < 10) begin
      step();
      n++;
    end
    if (!bus.ld_ready) begin
      chk("ld_ready_timeout", 32'(bus.ld_ready), 32'd1);
    end else begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      model[ld_ptr] = d;
      ld_ptr++;
      step();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      chk("load_mdrout_zero", 32'(bus.MDROut), 32'd0);
    end
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (bus.cpu_hold && n < 200) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'd64);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 6'd10, 10'h123, 10'h000};
    vecs[1] = '{1'b0, 6'd10, 10'h000, 10'h123};
    vecs[2] = '{1'b1, 6'd10, 10'h0F0, 10'h123};
    vecs[3] = '{1'b0, 6'd10, 10'h000, 10'h0F0};
    vecs[4] = '{1'b1, 6'd63, 10'h3FF, 10'h000};
    vecs[5] = '{1'b1, 6'd8,  10'h001, 10'h000};
    vecs[6] = '{1'b0, 6'd63, 10'h000, 10'h3FF};
    vecs[7] = '{1'b0, 6'd8,  10'h000, 10'h001};
    vecs[8] = '{1'b1, 6'd20, 10'h2AA, 10'h000};
    vecs[9] = '{1'b0, 6'd20, 10'h000, 10'h2AA};

    bus.MAR = '0; bus.MDRIn = '0; bus.RAMWr = 1'b0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    // 1. reset state, clear takes 64 cycles, array reads as zero
    #12;
    chk("rst_state",    32'(dbg_state),    32'(S_CLEAR));
    chk("rst_hold",     32'(bus.cpu_hold), 32'd1);
    chk("rst_mdrout",   32'(bus.MDROut),   32'd0);
    chk("rst_ready",    32'(bus.ld_ready), 32'd0);
    chk("rst_done",     32'(bus.ld_done),  32'd0);
    chk("rst_wr_fault", 32'(bus.wr_fault), 32'd0);
    #5 rst = 1'b1;
    wait_clear("clear_cycles");
    chk("run_state", 32'(dbg_state),    32'(S_RUN));
    chk("run_ready", 32'(bus.ld_ready), 32'd0);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // table-driven core accesses (addresses outside any protected region)
    for (int i = 0; i < 10; i++) begin
      bus.MAR   = vecs[i].addr;
      bus.MDRIn = vecs[i].wdata;
      bus.RAMWr = vecs[i].wr;
      exp_q.push_back(vecs[i].exp_rd);
      if (vecs[i].wr) model[vecs[i].addr] = vecs[i].wdata;
      step();
      bus.RAMWr = 1'b0;
      sb_check($sformatf("vec%0d", i));
    end

    // 2. write then read back address 5
    wr(6'd5, 10'h2A5);
    rd(6'd5);

    // 3. read-first on the same address
    wr(6'd7, 10'h011);
    rd(6'd7);
    wr(6'd7, 10'h3FF);
    rd(6'd7);

    // 5. full 64-word load with no ld_last, then a 65th word offered
    done_cnt = 0;
    start_load();
    bus.ld_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_data = DW'($urandom_range(1, 1023));
      model[i] = bus.ld_data;
      step();
      if (i == 62) chk("full_no_early_done", 32'(bus.ld_done), 32'd0);
    end
    bus.ld_data = 10'h3CC;              // 65th word, must not land anywhere
    chk("full_done",  32'(bus.ld_done),  32'd1);
    chk("full_ready", 32'(bus.ld_ready), 32'd0);
    chk("full_hold",  32'(bus.cpu_hold), 32'd0);
    step();
    bus.ld_valid = 1'b0;
    chk("full_done_pulse", 32'(bus.ld_done), 32'd0);
    chk("full_done_cnt",   32'(done_cnt),    32'd1);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // 4. three-word image with a valid gap; word 3 keeps its value
    done_cnt = 0;
    start_load();
    ld_word(10'h180, 1'b0);
    step();                              // ld_valid=0 gap
    chk("gap_state", 32'(dbg_state), 32'(S_LOAD));
    ld_word(10'h241, 1'b0);
    ld_word(10'h300, 1'b1);
    chk("img_done",  32'(bus.ld_done),  32'd1);
    chk("img_hold",  32'(bus.cpu_hold), 32'd0);
    chk("img_ready", 32'(bus.ld_ready), 32'd0);
    chk("img_state", 32'(dbg_state),    32'(S_RUN));
    step();
    chk("img_done_cnt", 32'(done_cnt), 32'd1);
    for (int a = 0; a < 4; a++) rd(AW'(a));

    // ld_start in LOAD is ignored: pointer keeps moving forward
    start_load();
    bus.ld_start = 1'b1;
    ld_word(10'h0AA, 1'b0);
    bus.ld_start = 1'b0;
    ld_word(10'h0BB, 1'b1);
    rd(6'd0);
    rd(6'd1);

    // 6. write protection
    wr(6'd3, 10'h155);
    rd(6'd3);
`ifdef FBCPU_MEM_WRPROT_EN
    chk("wr_fault_set", 32'(bus.wr_fault), 32'd1);
`else
    chk("wr_fault_off", 32'(bus.wr_fault), 32'd0);
`endif
    wr(6'd8, 10'h0C3);
    rd(6'd8);

    // reset in the middle of a load
    start_load();
    ld_word(10'h111, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state",    32'(dbg_state),    32'(S_CLEAR));
    chk("midrst_hold",     32'(bus.cpu_hold), 32'd1);
    chk("midrst_ready",    32'(bus.ld_ready), 32'd0);
    chk("midrst_mdrout",   32'(bus.MDROut),   32'd0);
    chk("midrst_wr_fault", 32'(bus.wr_fault), 32'd0);
    #3 rst = 1'b1;
    wait_clear("reclear_cycles");
    rd(6'd0);
    rd(6'd3);
    rd(6'd8);
    rd(6'd63);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
